wordle_guess_ctrl: RTL and testbench
====================================

Name: wordle_guess_ctrl

Overview:
- Sequences one Wordle game on the Nexys4 design.
- Accepts letter-select, delete and enter pulses; the letter comes from the on-screen keyboard cursor.
- Builds a WORD_LEN-letter guess, scores it against a latched target word with a two-pass green/yellow algorithm, and tracks attempts until win or loss.
- Sits between the keyboard cursor block and the display/VGA renderer.

Parameters:
- WORD_LEN, 5: letters per guess; scoring latency is 2*WORD_LEN cycles.
- MAX_TRIES, 6: guesses allowed before loss.
- LETTER_W, 5: letter code width. Codes: 0=A … 25=Z, 26=',', 27='.'.

Ports:
- Clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- Start  in  1  begin game; target is sampled this cycle
- Ack  in  1  acknowledge end of game
- target  in  WORD_LEN*LETTER_W  secret word; position i is at [LETTER_W*i +: LETTER_W], position 0 leftmost
- letter  in  LETTER_W  current keyboard letter code
- sel  in  1  single-cycle pulse: append letter
- del  in  1  single-cycle pulse: backspace
- enter  in  1  single-cycle pulse: submit guess
- q_I, q_Entry, q_Score, q_Won, q_Lost  out  1 each  one-hot state flags
- guess_letters  out  WORD_LEN*LETTER_W  current guess buffer, same packing as target
- guess_len  out  3  letters entered, 0..WORD_LEN
- attempt  out  3  completed guesses, 0..MAX_TRIES
- result_color  out  2*WORD_LEN  per-position colour: 00 gray, 01 yellow, 10 green; [2i+1:2i] is position i
- result_valid  out  1  one-cycle pulse when result_color is final
- err  out  1  one-cycle pulse on a rejected action

Behaviour:
- Reset: state QI. guess_letters=0, guess_len=0, attempt=0, result_color=0, result_valid=0, err=0, internal target latch=0. Reset mid-score aborts scoring and drops any partial result.
- QI: Start latches target, clears the buffer and attempt, then goes to QEntry. All other inputs are ignored.
- QEntry, priority enter > del > sel (one action per cycle):
  - sel with guess_len<WORD_LEN and letter<=25: store letter at position guess_len; guess_len+1.
  - sel with a full buffer or letter code 26/27: err pulse, buffer unchanged.
  - del with guess_len>0: clear the last letter to 0; guess_len-1. del with guess_len==0: ignored, no err.
  - enter with guess_len<WORD_LEN: err pulse, no state change.
  - enter with guess_len==WORD_LEN: snapshot the guess, go to QScore.
- QScore, pass 1 (WORD_LEN cycles, position i in cycle i):
  - guess[i]==target[i]: colour[i]=green.
  - Otherwise colour[i]=gray and unused[i]=1.
- QScore, pass 2 (WORD_LEN cycles):
  - For each non-green position i, find the lowest j with unused[j] && target[j]==guess[i].
  - If found: colour[i]=yellow and clear unused[j]. Otherwise gray.
  - Duplicate letters are therefore coloured at most as many times as they occur in the target.
- After pass 2:
  - result_valid pulses one cycle and attempt increments (saturating at MAX_TRIES).
  - All green: go to QWon.
  - Else if attempt==MAX_TRIES: go to QLost.
  - Else clear the buffer and guess_len, return to QEntry.
  - result_color holds until the next enter is accepted, Start, or reset.
- sel/del/enter during QScore are dropped; there is no queuing.
- QWon/QLost: hold all outputs. Ack returns to QI. Start is ignored.
- Latency: enter accepted at cycle N gives result_valid at cycle N+2*WORD_LEN+1.

Optional Feature:
- Macro WORDLE_HARD_MODE_EN.
- Defined:
  - Keep a green_seen mask that accumulates across attempts and clears on Start.
  - An enter with a full buffer where some position has green_seen[i]=1 and guess[i]!=target[i] pulses err and stays in QEntry.
- Undefined: no mask register and no extra check; behaviour exactly as above.

Decomposition:
- Package wordle_pkg:
  - Letter code constants (LTR_A=0, LTR_COMMA=26, LTR_PERIOD=27).
  - Colour constants COL_GRAY/COL_YELLOW/COL_GREEN.
  - One-hot state localparams.
  - Default WORD_LEN/MAX_TRIES.
- Sub-module wordle_score_unit:
  - Owns the two-pass scorer: unused mask, pass counter, lowest-j search.
  - Started by a go pulse; returns a done pulse plus colours.
  - The controller owns entry, attempts and game states.

Test Plan:
- Target "CRANE"; sel C,R,A,N,E then enter -> result_valid 11 cycles after enter; result_color all green; q_Won=1, attempt=1; Ack -> q_I.
- Target "APPLE", guess "PAPER" -> colours Y,Y,G,Y,gray; attempt=1; back in QEntry with guess_len=0.
- Target "ABBEY", guess "BOBBY" -> Y,gray,G,gray,G (third B gray: duplicate limit).
- Entry edges:
  - enter at guess_len=3 -> err pulse, stays in QEntry.
  - sel of code 27 -> err.
  - 6th sel -> err, guess_len stays 5.
  - del at 0 -> no change.
  - sel+del same cycle at guess_len=2 -> guess_len=1.
- Six wrong guesses on "CRANE" -> q_Lost after the 6th result_valid, attempt=6.
- Reset asserted mid-QScore -> next cycle q_I=1 and all outputs at reset values.
- Hard mode (macro defined): after a green C in position 0, guess "BLOKE" -> err, no scoring.

Source files
------------

// File: rtl/wordle_pkg.sv
// Shared constants for the Wordle game controller: letter codes, colours,
// one-hot state encoding and default game dimensions.
package wordle_pkg;

    localparam int WORD_LEN_DEF  = 5;
    localparam int MAX_TRIES_DEF = 6;
    localparam int LETTER_W_DEF  = 5;

    localparam int LTR_A      = 0;
    localparam int LTR_Z      = 25;
    localparam int LTR_COMMA  = 26;
    localparam int LTR_PERIOD = 27;

    localparam logic [1:0] COL_GRAY   = 2'b00;
    localparam logic [1:0] COL_YELLOW = 2'b01;
    localparam logic [1:0] COL_GREEN  = 2'b10;

    localparam int ST_I_BIT     = 0;
    localparam int ST_ENTRY_BIT = 1;
    localparam int ST_SCORE_BIT = 2;
    localparam int ST_WON_BIT   = 3;
    localparam int ST_LOST_BIT  = 4;

    typedef enum logic [4:0] {
        QI     = 5'b00001,
        QENTRY = 5'b00010,
        QSCORE = 5'b00100,
        QWON   = 5'b01000,
        QLOST  = 5'b10000
    } state_t;

endpackage

// File: rtl/wordle_score_unit.sv
// Two-pass green/yellow scorer: WORD_LEN cycles of exact matches, then WORD_LEN
// cycles of lowest-unused-position yellow search. done is high in the final cycle.
module wordle_score_unit
    import wordle_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF,
    parameter int LETTER_W = LETTER_W_DEF
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         go,
    input  logic [WORD_LEN*LETTER_W-1:0] guess,
    input  logic [WORD_LEN*LETTER_W-1:0] target,
    output logic                         done,
    output logic [2*WORD_LEN-1:0]        color
);
    localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

    logic [LETTER_W-1:0] guess_reg [WORD_LEN];
    logic [LETTER_W-1:0] tgt       [WORD_LEN];
    logic [1:0]          color_reg [WORD_LEN];
    logic [WORD_LEN-1:0] unused_reg;
    logic                busy_reg;
    logic                pass_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [LETTER_W-1:0] cur_guess;
    logic                hit_found;
    logic [IDX_W-1:0]    hit_idx;

    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_pack
            assign tgt[gi]             = target[LETTER_W*gi +: LETTER_W];
            assign color[2*gi +: 2]    = color_reg[gi];
        end
    endgenerate

    assign cur_guess = guess_reg[idx_reg];
    assign done      = busy_reg && pass_reg && (idx_reg == LAST_IDX);

    // Descending scan so the last hit written is the lowest matching position.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (unused_reg[j] && (tgt[j] == cur_guess)) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            busy_reg   <= 1'b0;
            pass_reg   <= 1'b0;
            idx_reg    <= '0;
            unused_reg <= '0;
            for (int i = 0; i < WORD_LEN; i++) begin
                guess_reg[i] <= '0;
                color_reg[i] <= COL_GRAY;
            end
        end else if (clear) begin
            busy_reg <= 1'b0;
            for (int i = 0; i < WORD_LEN; i++) color_reg[i] <= COL_GRAY;
        end else if (go) begin
            busy_reg   <= 1'b1;
            pass_reg   <= 1'b0;
            idx_reg    <= '0;
            unused_reg <= '0;
            for (int i = 0; i < WORD_LEN; i++) begin
                guess_reg[i] <= guess[LETTER_W*i +: LETTER_W];
                color_reg[i] <= COL_GRAY;
            end
        end else if (busy_reg) begin
            if (!pass_reg) begin
                if (cur_guess == tgt[idx_reg]) begin
                    color_reg[idx_reg]  <= COL_GREEN;
                    unused_reg[idx_reg] <= 1'b0;
                end else begin
                    color_reg[idx_reg]  <= COL_GRAY;
                    unused_reg[idx_reg] <= 1'b1;
                end
            end else if ((color_reg[idx_reg] != COL_GREEN) && hit_found) begin
                color_reg[idx_reg]  <= COL_YELLOW;
                unused_reg[hit_idx] <= 1'b0;
            end
            if (idx_reg == LAST_IDX) begin
                idx_reg  <= '0;
                pass_reg <= 1'b1;
                busy_reg <= !pass_reg;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wordle_guess_ctrl.sv
// Wordle game sequencer: guess entry, scoring handoff, attempts and win/loss.
// Optional macro WORDLE_HARD_MODE_EN rejects guesses that drop a known green.
module wordle_guess_ctrl
    import wordle_pkg::*;
#(
    parameter int WORD_LEN  = WORD_LEN_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF,
    parameter int LETTER_W  = LETTER_W_DEF
) (
    input  logic                         Clk,
    input  logic                         reset,
    input  logic                         Start,
    input  logic                         Ack,
    input  logic [WORD_LEN*LETTER_W-1:0] target,
    input  logic [LETTER_W-1:0]          letter,
    input  logic                         sel,
    input  logic                         del,
    input  logic                         enter,
    output logic                         q_I,
    output logic                         q_Entry,
    output logic                         q_Score,
    output logic                         q_Won,
    output logic                         q_Lost,
    output logic [WORD_LEN*LETTER_W-1:0] guess_letters,
    output logic [2:0]                   guess_len,
    output logic [2:0]                   attempt,
    output logic [2*WORD_LEN-1:0]        result_color,
    output logic                         result_valid,
    output logic                         err
);
    localparam logic [2:0] FULL_LEN  = 3'(WORD_LEN);
    localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);

    state_t                        state_reg, state_next;
    logic [WORD_LEN*LETTER_W-1:0]  target_reg, target_next;
    logic [LETTER_W-1:0]           buf_reg [WORD_LEN];
    logic [LETTER_W-1:0]           buf_next [WORD_LEN];
    logic [2:0]                    len_reg, len_next;
    logic [2:0]                    attempt_reg, attempt_next;
    logic                          rv_reg, rv_next;
    logic                          err_reg, err_next;
    logic                          score_go, score_clear, score_done;
    logic [WORD_LEN-1:0]           green_mask;
    logic                          all_green;
    logic                          hard_block;

    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_bus
            assign guess_letters[LETTER_W*gi +: LETTER_W] = buf_reg[gi];
            assign green_mask[gi] = (result_color[2*gi +: 2] == COL_GREEN);
        end
    endgenerate
    assign all_green = &green_mask;

`ifdef WORDLE_HARD_MODE_EN
    logic [WORD_LEN-1:0] green_seen_reg, green_seen_next, hard_miss;

    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_hard
            assign hard_miss[gi] = green_seen_reg[gi] &&
                                   (buf_reg[gi] != target_reg[LETTER_W*gi +: LETTER_W]);
        end
    endgenerate
    assign hard_block = |hard_miss;

    always_comb begin
        green_seen_next = green_seen_reg;
        if ((state_reg == QI) && Start)
            green_seen_next = '0;
        else if ((state_reg == QSCORE) && score_done)
            green_seen_next = green_seen_reg | green_mask;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) green_seen_reg <= '0;
        else       green_seen_reg <= green_seen_next;
    end
`else
    assign hard_block = 1'b0;
`endif

    wordle_score_unit #(.WORD_LEN(WORD_LEN), .LETTER_W(LETTER_W)) u_score (
        .Clk    (Clk),
        .reset  (reset),
        .clear  (score_clear),
        .go     (score_go),
        .guess  (guess_letters),
        .target (target_reg),
        .done   (score_done),
        .color  (result_color)
    );

    always_comb begin
        state_next   = state_reg;
        target_next  = target_reg;
        buf_next     = buf_reg;
        len_next     = len_reg;
        attempt_next = attempt_reg;
        rv_next      = 1'b0;
        err_next     = 1'b0;
        score_go     = 1'b0;
        score_clear  = 1'b0;
        case (state_reg)
            QI: begin
                if (Start) begin
                    target_next  = target;
                    for (int i = 0; i < WORD_LEN; i++) buf_next[i] = LETTER_W'(LTR_A);
                    len_next     = '0;
                    attempt_next = '0;
                    score_clear  = 1'b1;
                    state_next   = QENTRY;
                end
            end
            QENTRY: begin
                if (enter) begin
                    if ((len_reg != FULL_LEN) || hard_block) begin
                        err_next = 1'b1;
                    end else begin
                        score_go   = 1'b1;
                        state_next = QSCORE;
                    end
                end else if (del) begin
                    if (len_reg != 3'd0) begin
                        for (int i = 0; i < WORD_LEN; i++)
                            if (3'(i) == len_reg - 3'd1) buf_next[i] = LETTER_W'(LTR_A);
                        len_next = len_reg - 3'd1;
                    end
                end else if (sel) begin
                    if ((len_reg < FULL_LEN) && (32'(letter) <= LTR_Z)) begin
                        for (int i = 0; i < WORD_LEN; i++)
                            if (3'(i) == len_reg) buf_next[i] = letter;
                        len_next = len_reg + 3'd1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            QSCORE: begin
                // Greens are settled after pass 1, so all_green is valid on done.
                if (score_done) begin
                    rv_next = 1'b1;
                    if (attempt_reg < TRIES_MAX) attempt_next = attempt_reg + 3'd1;
                    if (all_green) begin
                        state_next = QWON;
                    end else if (attempt_next == TRIES_MAX) begin
                        state_next = QLOST;
                    end else begin
                        for (int i = 0; i < WORD_LEN; i++) buf_next[i] = LETTER_W'(LTR_A);
                        len_next   = '0;
                        state_next = QENTRY;
                    end
                end
            end
            QWON, QLOST: begin
                if (Ack) state_next = QI;
            end
            default: state_next = QI;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_reg   <= QI;
            target_reg  <= '0;
            len_reg     <= '0;
            attempt_reg <= '0;
            rv_reg      <= 1'b0;
            err_reg     <= 1'b0;
            for (int i = 0; i < WORD_LEN; i++) buf_reg[i] <= '0;
        end else begin
            state_reg   <= state_next;
            target_reg  <= target_next;
            len_reg     <= len_next;
            attempt_reg <= attempt_next;
            rv_reg      <= rv_next;
            err_reg     <= err_next;
            buf_reg     <= buf_next;
        end
    end

    assign q_I          = state_reg[ST_I_BIT];
    assign q_Entry      = state_reg[ST_ENTRY_BIT];
    assign q_Score      = state_reg[ST_SCORE_BIT];
    assign q_Won        = state_reg[ST_WON_BIT];
    assign q_Lost       = state_reg[ST_LOST_BIT];
    assign guess_len    = len_reg;
    assign attempt      = attempt_reg;
    assign result_valid = rv_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_wordle_guess_ctrl.sv
// Directed bench for wordle_guess_ctrl: entry vector table plus scoring,
// win/loss, reset-abort and (when WORDLE_HARD_MODE_EN is defined) hard-mode sequences.
module tb_wordle_guess_ctrl;

    logic        Clk = 1'b0;
    logic        reset, Start, Ack, sel, del, enter;
    logic [24:0] target;
    logic [4:0]  letter;
    logic        q_I, q_Entry, q_Score, q_Won, q_Lost;
    logic [24:0] guess_letters;
    logic [2:0]  guess_len, attempt;
    logic [9:0]  result_color;
    logic        result_valid, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    wordle_guess_ctrl dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .target(target),
        .letter(letter), .sel(sel), .del(del), .enter(enter),
        .q_I(q_I), .q_Entry(q_Entry), .q_Score(q_Score), .q_Won(q_Won), .q_Lost(q_Lost),
        .guess_letters(guess_letters), .guess_len(guess_len), .attempt(attempt),
        .result_color(result_color), .result_valid(result_valid), .err(err)
    );

    typedef struct {
        logic       s;
        logic       d;
        logic       e;
        logic [4:0] l;
        logic [2:0] len;
        logic       err;
        logic       entry;
    } vec_t;

    vec_t tbl [15];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [24:0] word(string s);
        logic [24:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) w[5*i +: 5] = 5'(s[i] - 8'd65);
        return w;
    endfunction

    function automatic logic [9:0] cols(string s);
        logic [9:0] c;
        c = '0;
        for (int i = 0; i < 5; i++) begin
            if (s[i] == "G")      c[2*i +: 2] = 2'b10;
            else if (s[i] == "Y") c[2*i +: 2] = 2'b01;
        end
        return c;
    endfunction

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply(logic s, logic d, logic e, logic [4:0] l);
        sel = s; del = d; enter = e; letter = l;
        cyc();
        sel = 1'b0; del = 1'b0; enter = 1'b0;
        $display("t=%0t sel=%0b del=%0b enter=%0b letter=%0d -> len=%0d err=%0b",
                 $time, s, d, e, l, guess_len, err);
    endtask

    task automatic start_game(string t);
        target = word(t);
        Start  = 1'b1;
        cyc();
        Start  = 1'b0;
        $display("t=%0t start target=%s", $time, t);
    endtask

    task automatic type_word(string w);
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 1'b0, 5'(w[i] - 8'd65));
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    // Enter, then count cycles to result_valid (10 counted cycles = N+11).
    task automatic submit(string tag, string exp_col, bit poke);
        int cnt;
        enter = 1'b1;
        cyc();
        enter = 1'b0;
        cnt = 0;
        while (!result_valid && cnt < 40) begin
            if (poke && cnt == 0) begin
                sel = 1'b1; letter = 5'd3;
            end
            cyc();
            sel = 1'b0;
            cnt++;
        end
        $display("t=%0t guess %s: result_color=%b after %0d cycles attempt=%0d",
                 $time, tag, result_color, cnt, attempt);
        check($sformatf("%s latency", tag), cnt, 10);
        check($sformatf("%s colour", tag), result_color, cols(exp_col));
        cyc();
        check($sformatf("%s valid pulse", tag), result_valid, 0);
    endtask

    initial begin
        reset = 1'b1; Start = 0; Ack = 0; sel = 0; del = 0; enter = 0;
        target = '0; letter = '0;
        repeat (3) cyc();
        check("reset q_I", q_I, 1);
        check("reset q_Entry", q_Entry, 0);
        check("reset guess_letters", guess_letters, 0);
        check("reset guess_len", guess_len, 0);
        check("reset attempt", attempt, 0);
        check("reset result_color", result_color, 0);
        check("reset result_valid", result_valid, 0);
        check("reset err", err, 0);
        reset = 1'b0;
        cyc();
        apply(1'b1, 1'b0, 1'b0, 5'd2);
        check("QI ignores sel", guess_len, 0);
        check("QI holds", q_I, 1);

        // Win on first guess
        start_game("CRANE");
        check("start to entry", q_Entry, 1);
        type_word("CRANE");
        check("crane buffer", guess_letters, word("CRANE"));
        check("crane len", guess_len, 5);
        submit("crane", "GGGGG", 1'b0);
        check("crane won", q_Won, 1);
        check("crane attempt", attempt, 1);
        check("crane buffer held", guess_letters, word("CRANE"));
        start_game("APPLE");
        check("won ignores Start", q_Won, 1);
        Ack = 1'b1; cyc(); Ack = 1'b0;
        check("ack to QI", q_I, 1);

        // Duplicate-letter limit
        start_game("ABBEY");
        type_word("BOBBY");
        submit("bobby", "YXGXG", 1'b0);
        check("bobby attempt", attempt, 1);
        check("bobby entry", q_Entry, 1);

        reset_dut();
        start_game("APPLE");
        type_word("PAPER");
        submit("paper", "YYGYX", 1'b0);
        check("paper attempt", attempt, 1);
        check("paper entry", q_Entry, 1);
        check("paper len cleared", guess_len, 0);
        check("paper buffer cleared", guess_letters, 0);

        // Entry edge vectors
        reset_dut();
        start_game("CRANE");
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd2,  3'd1, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd17, 3'd2, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 5'd17, 3'd1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'd0,  3'd0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd0,  3'd0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'd27, 3'd0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'd26, 3'd0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'd0,  3'd1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'd1,  3'd2, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'd2,  3'd3, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 5'd0,  3'd3, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 5'd3,  3'd4, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 5'd4,  3'd5, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 5'd5,  3'd5, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 5'd0,  3'd5, 1'b0, 1'b1};
        for (int v = 0; v < 15; v++) begin
            apply(tbl[v].s, tbl[v].d, tbl[v].e, tbl[v].l);
            check($sformatf("vec%0d len", v), guess_len, tbl[v].len);
            check($sformatf("vec%0d err", v), err, tbl[v].err);
            check($sformatf("vec%0d entry", v), q_Entry, tbl[v].entry);
        end
        check("vec buffer", guess_letters, word("ABCDE"));

        // Six wrong guesses -> loss
        submit("g1", "YXYXG", 1'b0);
        check("g1 attempt", attempt, 1);
        for (int g = 2; g <= 6; g++) begin
            type_word("ABCDE");
            check($sformatf("g%0d colour held", g), result_color, cols("YXYXG"));
            submit($sformatf("g%0d", g), "YXYXG", g == 2);
            check($sformatf("g%0d attempt", g), attempt, g);
            check($sformatf("g%0d entry", g), q_Entry, (g < 6) ? 1 : 0);
            check($sformatf("g%0d lost", g), q_Lost, (g == 6) ? 1 : 0);
            if (g < 6) check($sformatf("g%0d len", g), guess_len, 0);
        end
        Ack = 1'b1; cyc(); Ack = 1'b0;
        check("lost ack to QI", q_I, 1);

        // Reset in the middle of scoring
        start_game("CRANE");
        type_word("CRANE");
        apply(1'b0, 1'b0, 1'b1, 5'd0);
        check("abort in score", q_Score, 1);
        repeat (4) cyc();
        reset = 1'b1;
        #1;
        check("abort q_I", q_I, 1);
        check("abort q_Score", q_Score, 0);
        check("abort guess_letters", guess_letters, 0);
        check("abort guess_len", guess_len, 0);
        check("abort attempt", attempt, 0);
        check("abort result_color", result_color, 0);
        check("abort result_valid", result_valid, 0);
        cyc();
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 14; k++) begin
                cyc();
                if (result_valid) seen++;
            end
            check("abort no result", seen, 0);
            check("abort stays QI", q_I, 1);
        end

`ifdef WORDLE_HARD_MODE_EN
        reset_dut();
        start_game("CRANE");
        type_word("CLOTH");
        submit("cloth", "GXXXX", 1'b0);
        type_word("BLOKE");
        apply(1'b0, 1'b0, 1'b1, 5'd0);
        check("hard err", err, 1);
        check("hard entry", q_Entry, 1);
        check("hard no score", q_Score, 0);
        check("hard attempt", attempt, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
